// File: rtl/pcie_us_cq_route_ctrl_if.sv
// CQ-side bundle shared between the CQ demux and its routing controller.
// The demux (master) presents the decoded header fields and the monitored
// CQ handshake; the controller (slave) returns enable/drop/select.
interface pcie_us_cq_route_ctrl_if #(
  parameter int M_COUNT = 2
);
  logic [3:0]         req_type;
  logic [7:0]         target_function;
  logic [2:0]         bar_id;
  logic               s_axis_cq_tvalid;
  logic               s_axis_cq_tready;
  logic               s_axis_cq_tlast;
  logic               enable;
  logic               drop;
  logic [M_COUNT-1:0] select;

  modport master (
    output req_type, target_function, bar_id,
    output s_axis_cq_tvalid, s_axis_cq_tready, s_axis_cq_tlast,
    input  enable, drop, select
  );

  modport slave (
    input  req_type, target_function, bar_id,
    input  s_axis_cq_tvalid, s_axis_cq_tready, s_axis_cq_tlast,
    output enable, drop, select
  );
endinterface

// File: rtl/pcie_us_cq_route_ctrl.sv
// Routing controller for the Ultrascale CQ demux: decodes request type /
// function / BAR against a programmable BAR route table, drives the demux
// enable/drop/select, quiesces the stream at frame boundaries on request and
// keeps saturating per-output frame and drop statistics.
module pcie_us_cq_route_ctrl #(
  parameter int M_COUNT    = 2,
  parameter int FUNC_COUNT = 1,
  parameter int MSG_SELECT = 0,
  parameter int STAT_WIDTH = 32,
  parameter int CL_M_COUNT = (M_COUNT > 1) ? $clog2(M_COUNT) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  pcie_us_cq_route_ctrl_if.slave        cq,
  input  logic [M_COUNT-1:0]            out_enable,
  input  logic                          cfg_wr_en,
  input  logic [2:0]                    cfg_wr_addr,
  input  logic                          cfg_wr_valid,
  input  logic [CL_M_COUNT-1:0]         cfg_wr_sel,
  input  logic                          pause_req,
  output logic                          pause_ack,
  input  logic                          stat_clear,
  output logic [M_COUNT*STAT_WIDTH-1:0] stat_frame_count,
  output logic [STAT_WIDTH-1:0]         stat_drop_count
);

  localparam int OE_PAD = 2 ** CL_M_COUNT;

  typedef enum logic [1:0] {IDLE, FRAME, PAUSED} state_t;

  state_t                  state;
  state_t                  state_next;
  logic                    tbl_valid [8];
  logic [CL_M_COUNT-1:0]   tbl_sel   [8];
  logic [STAT_WIDTH-1:0]   frame_cnt [M_COUNT];
  logic [STAT_WIDTH-1:0]   drop_cnt;
  logic [OE_PAD-1:0]       oe_pad;
  logic                    route_ok;
  logic                    route_en;
  logic [CL_M_COUNT-1:0]   route_idx;
  logic                    beat;
  logic                    sof;

  assign beat   = cq.s_axis_cq_tvalid && cq.s_axis_cq_tready;
  assign sof    = beat && (state == IDLE);
  assign oe_pad = OE_PAD'(out_enable);

  // Route decision from the current header fields, the BAR table and the
  // per-output enables; only meaningful on a start-of-frame beat.
  always_comb begin
    route_ok  = 1'b0;
    route_idx = '0;
    if (cq.req_type[3:2] == 2'b00) begin
      route_idx = tbl_sel[cq.bar_id];
      route_ok  = tbl_valid[cq.bar_id]
                  && (int'(tbl_sel[cq.bar_id]) < M_COUNT)
                  && (int'(cq.target_function) < FUNC_COUNT);
    end else if (cq.req_type[3:1] == 3'b110) begin
      route_idx = CL_M_COUNT'(MSG_SELECT);
      route_ok  = (MSG_SELECT < M_COUNT);
    end
    route_en   = route_ok && oe_pad[route_idx];
    cq.drop    = !route_en;
    cq.select  = route_en ? ({{(M_COUNT-1){1'b0}}, 1'b1} << route_idx) : '0;
    cq.enable  = (state != PAUSED) && !((state == IDLE) && pause_req);
  end

  // Frame tracking and pause handling; pausing only happens between frames.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (beat && !cq.s_axis_cq_tlast) begin
          state_next = FRAME;
        end else if (pause_req) begin
          state_next = PAUSED;
        end
      end
      FRAME: begin
        if (beat && cq.s_axis_cq_tlast) begin
          state_next = pause_req ? PAUSED : IDLE;
        end
      end
      PAUSED: begin
        if (!pause_req) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and registered pause acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pause_ack <= 1'b0;
    end else begin
      state     <= state_next;
      pause_ack <= (state_next == PAUSED);
    end
  end

  // BAR route table; a write is seen by start-of-frame beats from the next cycle on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        tbl_valid[i] <= 1'b1;
        tbl_sel[i]   <= '0;
      end
    end else if (cfg_wr_en) begin
      tbl_valid[cfg_wr_addr] <= cfg_wr_valid;
      tbl_sel[cfg_wr_addr]   <= cfg_wr_sel;
    end
  end

  // Saturating frame/drop statistics counted on start-of-frame beats; clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < M_COUNT; i++) begin
        frame_cnt[i] <= '0;
      end
      drop_cnt <= '0;
    end else if (stat_clear) begin
      for (int i = 0; i < M_COUNT; i++) begin
        frame_cnt[i] <= '0;
      end
      drop_cnt <= '0;
    end else if (sof) begin
      if (route_en) begin
        for (int i = 0; i < M_COUNT; i++) begin
          if ((int'(route_idx) == i) && (frame_cnt[i] != '1)) begin
            frame_cnt[i] <= frame_cnt[i] + 1'b1;
          end
        end
      end else if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  assign stat_drop_count = drop_cnt;

  for (genvar g = 0; g < M_COUNT; g++) begin : g_stat
    assign stat_frame_count[g*STAT_WIDTH +: STAT_WIDTH] = frame_cnt[g];
  end

endmodule

// File: tb/tb_pcie_us_cq_route_ctrl.sv
// Self-checking bench for pcie_us_cq_route_ctrl: directed scenarios with
// literal expectations followed by randomized traffic, all compared every
// cycle against a frame-level behavioural model.
module tb_pcie_us_cq_route_ctrl;
  localparam int M   = 2;
  localparam int FC  = 1;
  localparam int MSG = 1;
  localparam int SW  = 4;
  localparam int CL  = 1;
  localparam int MAXC = (1 << SW) - 1;

  logic            clk;
  logic            rst;
  logic [M-1:0]    out_enable;
  logic            cfg_wr_en;
  logic [2:0]      cfg_wr_addr;
  logic            cfg_wr_valid;
  logic [CL-1:0]   cfg_wr_sel;
  logic            pause_req;
  logic            pause_ack;
  logic            stat_clear;
  logic [M*SW-1:0] stat_frame_count;
  logic [SW-1:0]   stat_drop_count;

  int tests_run = 0;
  int tests_failed = 0;

  pcie_us_cq_route_ctrl_if #(.M_COUNT(M)) cq ();

  pcie_us_cq_route_ctrl #(
    .M_COUNT(M), .FUNC_COUNT(FC), .MSG_SELECT(MSG), .STAT_WIDTH(SW)
  ) dut (
    .clk(clk), .rst(rst), .cq(cq.slave), .out_enable(out_enable),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_valid(cfg_wr_valid),
    .cfg_wr_sel(cfg_wr_sel), .pause_req(pause_req), .pause_ack(pause_ack),
    .stat_clear(stat_clear), .stat_frame_count(stat_frame_count),
    .stat_drop_count(stat_drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: where the stream is (inside a frame / paused), the
  // route table contents and the statistic counts as plain integers.
  bit m_in_frame;
  bit m_paused;
  bit m_valid [8];
  int m_sel   [8];
  int m_frames [M];
  int m_drops;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_in_frame = 0;
    m_paused   = 0;
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1;
      m_sel[i]   = 0;
    end
    for (int i = 0; i < M; i++) m_frames[i] = 0;
    m_drops = 0;
  endfunction

  function automatic bit model_enable(input bit pr);
    if (m_paused) return 0;
    if (!m_in_frame && pr) return 0;
    return 1;
  endfunction

  // Returns the destination output index, or -1 when the frame is dropped.
  function automatic int model_route(input int rt, input int fn, input int bar, input logic [M-1:0] oe);
    int idx;
    bit ok;
    idx = 0;
    ok  = 0;
    if (rt <= 3) begin
      idx = m_sel[bar];
      ok  = m_valid[bar] && (idx < M) && (fn < FC);
    end else if (rt == 12 || rt == 13) begin
      idx = MSG;
      ok  = 1;
    end
    if (ok && oe[idx]) return idx;
    return -1;
  endfunction

  always @(posedge rst) model_reset();

  // Compare process: outputs against the model every cycle, then step the model.
  always @(negedge clk) begin
    bit beat;
    int r;
    if (rst) begin
      model_reset();
    end
    check_output("enable", 32'(cq.enable), 32'(model_enable(pause_req)));
    check_output("pause_ack", 32'(pause_ack), 32'(m_paused));
    for (int i = 0; i < M; i++)
      check_output("frame_count", 32'(stat_frame_count[i*SW +: SW]), 32'(m_frames[i]));
    check_output("drop_count", 32'(stat_drop_count), 32'(m_drops));
    if (!rst) begin
      beat = cq.s_axis_cq_tvalid && cq.s_axis_cq_tready;
      if (m_paused) begin
        if (!pause_req) m_paused = 0;
      end else if (!m_in_frame) begin
        if (beat) begin
          r = model_route(int'(cq.req_type), int'(cq.target_function), int'(cq.bar_id), out_enable);
          check_output("sof_drop", 32'(cq.drop), (r < 0) ? 32'd1 : 32'd0);
          check_output("sof_select", 32'(cq.select), (r < 0) ? 32'd0 : (32'd1 << r));
          if (r < 0) begin
            if (m_drops < MAXC) m_drops++;
          end else begin
            if (m_frames[r] < MAXC) m_frames[r]++;
          end
          if (!cq.s_axis_cq_tlast) m_in_frame = 1;
          else if (pause_req) m_paused = 1;
        end else if (pause_req) begin
          m_paused = 1;
        end
      end else if (beat && cq.s_axis_cq_tlast) begin
        m_in_frame = 0;
        m_paused   = pause_req;
      end
      if (stat_clear) begin
        for (int i = 0; i < M; i++) m_frames[i] = 0;
        m_drops = 0;
      end
      if (cfg_wr_en) begin
        m_valid[cfg_wr_addr] = cfg_wr_valid;
        m_sel[cfg_wr_addr]   = int'(cfg_wr_sel);
      end
    end
  end

  // One cycle of CQ traffic, driven just after the rising edge.
  task automatic apply_stimulus(input logic v, input logic [3:0] rt, input logic [7:0] fn,
                                input logic [2:0] bar, input logic last,
                                input logic pr = 1'b0, input logic clr = 1'b0);
    @(posedge clk);
    #1;
    cq.s_axis_cq_tvalid = v;
    cq.s_axis_cq_tready = 1'b1;
    cq.req_type         = rt;
    cq.target_function  = fn;
    cq.bar_id           = bar;
    cq.s_axis_cq_tlast  = last;
    pause_req           = pr;
    stat_clear          = clr;
    cfg_wr_en           = 1'b0;
  endtask

  task automatic cfg_write(input logic [2:0] addr, input logic vld, input logic [CL-1:0] sel);
    apply_stimulus(1'b0, 4'd0, 8'd0, 3'd0, 1'b0);
    cfg_wr_en    = 1'b1;
    cfg_wr_addr  = addr;
    cfg_wr_valid = vld;
    cfg_wr_sel   = sel;
  endtask

  initial begin
    rst = 1'b1;
    out_enable = 2'b11;
    cfg_wr_en = 0; cfg_wr_addr = 0; cfg_wr_valid = 0; cfg_wr_sel = 0;
    pause_req = 0; stat_clear = 0;
    cq.req_type = 0; cq.target_function = 0; cq.bar_id = 0;
    cq.s_axis_cq_tvalid = 0; cq.s_axis_cq_tready = 0; cq.s_axis_cq_tlast = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_output("rst_enable", 32'(cq.enable), 32'd1);
    check_output("rst_pause_ack", 32'(pause_ack), 32'd0);
    check_output("rst_drops", 32'(stat_drop_count), 32'd0);

    // Single-beat memory write to bar 0 lands on output 0.
    apply_stimulus(1'b1, 4'b0001, 8'd0, 3'd0, 1'b1);
    #2;
    check_output("t1_select", 32'(cq.select), 32'b01);
    check_output("t1_drop", 32'(cq.drop), 32'd0);
    apply_stimulus(1'b0, 4'd0, 8'd0, 3'd0, 1'b0);
    #2 check_output("t1_frames0", 32'(stat_frame_count[SW-1:0]), 32'd1);

    // Re-point bar 2 to output 1, then a three-beat read.
    cfg_write(3'd2, 1'b1, 1'b1);
    apply_stimulus(1'b1, 4'b0000, 8'd0, 3'd2, 1'b0);
    #2 check_output("t2_select", 32'(cq.select), 32'b10);
    apply_stimulus(1'b1, 4'b0000, 8'd0, 3'd2, 1'b0);
    apply_stimulus(1'b1, 4'b0000, 8'd0, 3'd2, 1'b1);
    apply_stimulus(1'b0, 4'd0, 8'd0, 3'd0, 1'b0);
    #2 check_output("t2_frames1", 32'(stat_frame_count[2*SW-1:SW]), 32'd1);

    // Three kinds of drop: invalid entry, bad function, unsupported type.
    cfg_write(3'd5, 1'b0, 1'b0);
    apply_stimulus(1'b1, 4'b0001, 8'd0, 3'd5, 1'b1);
    #2 check_output("t3_drop_bar", 32'({cq.drop, cq.select}), 32'b100);
    apply_stimulus(1'b1, 4'b0001, 8'd1, 3'd0, 1'b1);
    #2 check_output("t3_drop_fn", 32'({cq.drop, cq.select}), 32'b100);
    apply_stimulus(1'b1, 4'b0110, 8'd0, 3'd0, 1'b1);
    #2 check_output("t3_drop_type", 32'({cq.drop, cq.select}), 32'b100);
    apply_stimulus(1'b0, 4'd0, 8'd0, 3'd0, 1'b0);
    #2 check_output("t3_drops", 32'(stat_drop_count), 32'd3);

    // Pause raised mid-frame takes effect only after tlast.
    apply_stimulus(1'b1, 4'b0001, 8'd0, 3'd0, 1'b0);
    apply_stimulus(1'b1, 4'b0001, 8'd0, 3'd0, 1'b0, 1'b1);
    #2 check_output("t4_enable_b2", 32'(cq.enable), 32'd1);
    apply_stimulus(1'b1, 4'b0001, 8'd0, 3'd0, 1'b0, 1'b1);
    apply_stimulus(1'b1, 4'b0001, 8'd0, 3'd0, 1'b1, 1'b1);
    #2 check_output("t4_enable_last", 32'(cq.enable), 32'd1);
    apply_stimulus(1'b0, 4'd0, 8'd0, 3'd0, 1'b0, 1'b1);
    #2;
    check_output("t4_pause_ack", 32'(pause_ack), 32'd1);
    check_output("t4_enable_paused", 32'(cq.enable), 32'd0);
    apply_stimulus(1'b0, 4'd0, 8'd0, 3'd0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 4'd0, 8'd0, 3'd0, 1'b0, 1'b0);
    #2;
    check_output("t4_enable_resume", 32'(cq.enable), 32'd1);
    check_output("t4_ack_resume", 32'(pause_ack), 32'd0);

    // Drop counter saturation and clear priority.
    apply_stimulus(1'b0, 4'd0, 8'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < MAXC; i++) apply_stimulus(1'b1, 4'b0110, 8'd0, 3'd0, 1'b1);
    apply_stimulus(1'b0, 4'd0, 8'd0, 3'd0, 1'b0);
    #2 check_output("t5_drops_full", 32'(stat_drop_count), 32'd15);
    apply_stimulus(1'b1, 4'b0110, 8'd0, 3'd0, 1'b1);
    apply_stimulus(1'b0, 4'd0, 8'd0, 3'd0, 1'b0);
    #2 check_output("t5_drops_sat", 32'(stat_drop_count), 32'd15);
    apply_stimulus(1'b1, 4'b0110, 8'd0, 3'd0, 1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b0, 4'd0, 8'd0, 3'd0, 1'b0);
    #2 check_output("t5_drops_clr", 32'(stat_drop_count), 32'd0);

    // Asynchronous reset in the middle of a frame.
    apply_stimulus(1'b1, 4'b0001, 8'd0, 3'd0, 1'b0);
    @(posedge clk);
    #2;
    check_output("t6_pre_frames0", 32'(stat_frame_count[SW-1:0]), 32'd1);
    rst = 1'b1;
    cq.s_axis_cq_tvalid = 1'b0;
    #1;
    check_output("t6_enable", 32'(cq.enable), 32'd1);
    check_output("t6_pause_ack", 32'(pause_ack), 32'd0);
    check_output("t6_frames0", 32'(stat_frame_count[SW-1:0]), 32'd0);
    rst = 1'b0;
    apply_stimulus(1'b1, 4'b0001, 8'd0, 3'd2, 1'b1);
    #2 check_output("t6_tbl2_default", 32'(cq.select), 32'b01);
    apply_stimulus(1'b1, 4'b0001, 8'd0, 3'd5, 1'b1);
    #2 check_output("t6_tbl5_default", 32'(cq.drop), 32'd0);

    // Randomized traffic checked by the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(19) == 0) pause_req = ~pause_req;
      case ($urandom_range(6))
        0: cq.req_type = 4'd0;
        1: cq.req_type = 4'd1;
        2: cq.req_type = 4'd2;
        3: cq.req_type = 4'd3;
        4: cq.req_type = 4'd12;
        5: cq.req_type = 4'd13;
        default: cq.req_type = 4'($urandom_range(15));
      endcase
      cq.target_function  = 8'($urandom_range(2));
      cq.bar_id           = 3'($urandom_range(7));
      cq.s_axis_cq_tlast  = ($urandom_range(2) == 0);
      cq.s_axis_cq_tvalid = ($urandom_range(3) != 0);
      cq.s_axis_cq_tready = model_enable(pause_req) && ($urandom_range(3) != 0);
      out_enable          = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b11;
      cfg_wr_en           = ($urandom_range(7) == 0);
      cfg_wr_addr         = 3'($urandom_range(7));
      cfg_wr_valid        = ($urandom_range(3) != 0);
      cfg_wr_sel          = 1'($urandom_range(1));
      stat_clear          = ($urandom_range(63) == 0);
      if ($urandom_range(399) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end

    apply_stimulus(1'b0, 4'd0, 8'd0, 3'd0, 1'b0);
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
